// File: rtl/beta_pkg.sv
// Shared constants and types for the beta instruction fetch stage.
package beta_pkg;

   localparam logic [31:0] BETA_NOP    = 32'h0000_0013;
   localparam int          INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      DISCARD
   } fetch_state_e;

endpackage

// File: rtl/beta_fetch_fifo.sv
// Small synchronous prefetch FIFO with clear, combinational head and occupancy count.
module beta_fetch_fifo #(
   parameter int Width = 33,
   parameter int Depth = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [Width-1:0]         wr_data,
   output logic [Width-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(Depth):0]   count
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr_reg;
   logic [PtrW-1:0]  rd_ptr_reg;
   logic [CntW-1:0]  count_reg;
   logic             do_push;
   logic             do_pop;

   // A pop frees its slot in the same cycle, so a full FIFO may still accept a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wr_data;
   end

   assign head  = mem[rd_ptr_reg];
   assign empty = (count_reg == '0);
   assign full  = (count_reg == CntW'(Depth));
   assign count = count_reg;

endmodule

// File: rtl/beta_fetch_stage.sv
// Instruction fetch stage: PC, in-order req/gnt/rvalid fetch, prefetch FIFO and redirect flush.
// Define BETA_FETCH_ERR_EN to carry imem_err_i per entry and report it on fetch_fault_o.
module beta_fetch_stage import beta_pkg::*; #(
   parameter int                   DataWidth = 32,
   parameter logic [DataWidth-1:0] BootAddr  = '0,
   parameter int                   FifoDepth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 imem_req_o,
   output logic [DataWidth-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [DataWidth-1:0] imem_rdata_i,
   input  logic                 imem_err_i,
   input  logic                 redirect_i,
   input  logic [DataWidth-1:0] redirect_pc_i,
   input  logic                 fetch_stall_i,
   output logic [DataWidth-1:0] pip_instr_o,
   output logic                 pip_new_instr_o,
   output logic [DataWidth-1:0] pip_next_pc_o,
   output logic                 fetch_fault_o
);

   localparam int CntW = $clog2(FifoDepth) + 1;
   localparam int SumW = CntW + 1;
`ifdef BETA_FETCH_ERR_EN
   localparam int FifoWidth = DataWidth + 1;
`else
   localparam int FifoWidth = DataWidth;
`endif

   fetch_state_e         state_q, state_next;
   logic [DataWidth-1:0] pc_q, out_pc_q;
   logic [CntW-1:0]      outstanding_q, outstanding_next;
   logic [CntW-1:0]      discard_q, discard_next;
   logic [CntW-1:0]      fifo_count;
   logic                 fifo_empty, fifo_push, fifo_pop;
   logic                 unused_fifo_full;
   logic [FifoWidth-1:0] fifo_head, fifo_wdata;
   logic                 accept, rsp_valid, credit_ok;

   always_comb begin
      fifo_pop  = ~fifo_empty & ~fetch_stall_i & ~redirect_i;
      // The entry popped this cycle counts as free so gnt=1 / 1-cycle rvalid sustains 1 instr/cycle.
      credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count} - SumW'(fifo_pop)) < SumW'(FifoDepth);
      imem_req_o  = (state_q != BOOT) & ~redirect_i & credit_ok;
      imem_addr_o = pc_q;
      accept    = imem_req_o & imem_gnt_i;
      rsp_valid = imem_rvalid_i & (outstanding_q != '0);
      outstanding_next = outstanding_q + CntW'(accept) - CntW'(rsp_valid);

      discard_next = discard_q;
      if (redirect_i)
         discard_next = outstanding_q - CntW'(rsp_valid);
      else if (rsp_valid && discard_q != '0)
         discard_next = discard_q - 1'b1;

      fifo_push = rsp_valid & ~redirect_i & (discard_q == '0);

      state_next = state_q;
      case (state_q)
         BOOT:    state_next = RUN;
         default: state_next = (discard_next != '0) ? DISCARD : RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= BOOT;
         pc_q          <= BootAddr;
         out_pc_q      <= BootAddr;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_next;
         outstanding_q <= outstanding_next;
         discard_q     <= discard_next;
         if (redirect_i) begin
            pc_q     <= redirect_pc_i;
            out_pc_q <= redirect_pc_i;
         end else begin
            if (accept)   pc_q     <= pc_q + DataWidth'(INSTR_BYTES);
            if (fifo_pop) out_pc_q <= out_pc_q + DataWidth'(INSTR_BYTES);
         end
      end
   end

`ifdef BETA_FETCH_ERR_EN
   assign fifo_wdata    = {imem_rdata_i, imem_err_i};
   assign fetch_fault_o = fifo_head[0] & ~fifo_empty;
`else
   logic unused_err;
   assign unused_err    = imem_err_i;
   assign fifo_wdata    = imem_rdata_i;
   assign fetch_fault_o = 1'b0;
`endif

   beta_fetch_fifo #(
      .Width (FifoWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     (redirect_i),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (fifo_wdata),
      .head    (fifo_head),
      .empty   (fifo_empty),
      .full    (unused_fifo_full),
      .count   (fifo_count)
   );

   assign pip_new_instr_o = ~fifo_empty;
   assign pip_instr_o     = fifo_empty ? DataWidth'(BETA_NOP) : fifo_head[FifoWidth-1 -: DataWidth];
   assign pip_next_pc_o   = out_pc_q + DataWidth'(INSTR_BYTES);

endmodule

// File: tb/tb_beta_fetch_stage.sv
// Directed bench for beta_fetch_stage: in-order memory responder with programmable latency,
// instruction stream check (word = 0xC000_0000 | pc) plus stall, redirect, gnt-stall and reset vectors.
`timescale 1ns/1ps
module tb_beta_fetch_stage;

`ifdef BETA_FETCH_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, gnt, rvalid, err, redirect, stall;
   logic [31:0] rdata, rpc;
   logic        imem_req_o, pip_new_instr_o, fetch_fault_o;
   logic [31:0] imem_addr_o, pip_instr_o, pip_next_pc_o;

   always #5 clk = ~clk;

   beta_fetch_stage dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_gnt_i      (gnt),
      .imem_rvalid_i   (rvalid),
      .imem_rdata_i    (rdata),
      .imem_err_i      (err),
      .redirect_i      (redirect),
      .redirect_pc_i   (rpc),
      .fetch_stall_i   (stall),
      .pip_instr_o     (pip_instr_o),
      .pip_new_instr_o (pip_new_instr_o),
      .pip_next_pc_o   (pip_next_pc_o),
      .fetch_fault_o   (fetch_fault_o)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // In-order memory responder: a grant seen in cycle c returns in cycle c+lat.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;
   rsp_t pend[$];
   int   cyc = 0;
   int   lat = 1;

   initial begin : responder
      rsp_t r;
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
      err    = 1'b0;
      forever begin
         @(negedge clk); #4;
         if (imem_req_o && gnt) pend.push_back('{imem_addr_o, cyc + lat});
         @(posedge clk); #1;
         cyc++;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            r      = pend.pop_front();
            rvalid = 1'b1;
            rdata  = 32'hC000_0000 | r.addr;
            err    = (r.addr == 32'h8);
         end else begin
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
            err    = 1'b0;
         end
      end
   end

   logic [31:0] exp_pc;
   int          fault_seen;

   // One cycle: drive inputs at the falling edge, then check the head against the expected stream.
   task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic g);
      @(negedge clk);
      stall = s; redirect = r; rpc = rp; gnt = g;
      #2;
      if (pip_new_instr_o) begin
         chk("next_pc", pip_next_pc_o, exp_pc + 32'd4);
         chk("instr", pip_instr_o, 32'hC000_0000 | exp_pc);
         chk("fault", 32'(fetch_fault_o), 32'(ERR && exp_pc == 32'h8));
         if (fetch_fault_o) fault_seen++;
         if (!s && !r) begin
            $display("issue pc=%h instr=%h next_pc=%h", exp_pc, pip_instr_o, pip_next_pc_o);
            exp_pc = exp_pc + 32'd4;
         end
      end else begin
         chk("idle_instr", pip_instr_o, NOP);
         chk("idle_fault", 32'(fetch_fault_o), 32'd0);
      end
      if (r) exp_pc = rp;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] h;
      int          grants, n;
      rst = 1'b1; gnt = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = '0;
      exp_pc = 32'h0; fault_seen = 0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_new", 32'(pip_new_instr_o), 32'd0);
      chk("rst_instr", pip_instr_o, NOP);
      chk("rst_next_pc", pip_next_pc_o, 32'h4);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_fault", 32'(fetch_fault_o), 32'd0);

      // Boot and full-throughput stream, gnt=1, 1-cycle rvalid.
      @(negedge clk); rst = 1'b0; gnt = 1'b1; #2;
      chk("boot_no_req", 32'(imem_req_o), 32'd0);
      step(0, 0, 0, 1);
      chk("c1_req", 32'(imem_req_o), 32'd1);
      chk("c1_addr", imem_addr_o, 32'h0);
      step(0, 0, 0, 1);
      chk("c2_new", 32'(pip_new_instr_o), 32'd0);
      chk("c2_addr", imem_addr_o, 32'h4);
      step(0, 0, 0, 1);
      chk("c3_new", 32'(pip_new_instr_o), 32'd1);
      chk("c3_next_pc", pip_next_pc_o, 32'h4);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1);
         chk("tput_new", 32'(pip_new_instr_o), 32'd1);
      end

      // Stall for 5 cycles: head holds, request cap bounds the grants.
      h = exp_pc; grants = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1);
         if (imem_req_o && gnt) grants++;
         chk("stall_next_pc", pip_next_pc_o, h + 32'd4);
         chk("stall_instr", pip_instr_o, 32'hC000_0000 | h);
      end
      chk("stall_grants_le2", 32'(grants <= 2), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1);
         chk("release_new", 32'(pip_new_instr_o), 32'd1);
      end

      // gnt low for 10 cycles: request and address hold (head, one in flight, next request).
      h = exp_pc;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0);
         chk("nognt_req", 32'(imem_req_o), 32'd1);
         chk("nognt_addr", imem_addr_o, h + 32'd8);
      end

      // Two requests in flight (3-cycle latency), redirect to 0x100 drops both.
      lat = 3;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 1, 32'h100, 1);
      chk("redir_no_req", 32'(imem_req_o), 32'd0);
      step(0, 0, 0, 1);
      chk("redir_addr", imem_addr_o, 32'h100);
      n = 0;
      do begin step(0, 0, 0, 1); n++; end while (!pip_new_instr_o && n < 12);
      chk("redir_first_new", 32'(pip_new_instr_o), 32'd1);
      chk("redir_first_pc", pip_next_pc_o, 32'h104);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

      // Redirect coinciding with rvalid and stall: concurrent word and the other in-flight word dropped.
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      lat = 2;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 1, 32'h200, 1);
      chk("redir2_no_req", 32'(imem_req_o), 32'd0);
      chk("redir2_rvalid", 32'(rvalid), 32'd1);
      n = 0;
      do begin step(0, 0, 0, 1); n++; end while (!pip_new_instr_o && n < 12);
      chk("redir2_first_new", 32'(pip_new_instr_o), 32'd1);
      chk("redir2_first_pc", pip_next_pc_o, 32'h204);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      // Refetch from 0x0: the word at 0x8 carries a bus error.
      lat = 1;
      step(0, 1, 32'h0, 1);
      fault_seen = 0;
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
      chk("fault_cycles", 32'(fault_seen), ERR ? 32'd1 : 32'd0);

      // Reset mid-stream returns to the boot state.
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("rst2_new", 32'(pip_new_instr_o), 32'd0);
      chk("rst2_req", 32'(imem_req_o), 32'd0);
      chk("rst2_next_pc", pip_next_pc_o, 32'h4);
      chk("rst2_addr", imem_addr_o, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
